ps2_keyboard_rx: RTL and testbench
==================================

# ps2_keyboard_rx

Receive-only PS/2 keyboard host interface for the score/VGA display top level. It filters and synchronises the external `ps2_clk`/`ps2_data` lines and deserialises 11-bit device-to-host frames with start, parity and stop checks. It folds the E0 (extended) and F0 (break) prefixes into per-key flags and presents one registered key event per make or break code to game logic in the `clk` domain.

## Interface
- `FILTER_LEN`, 8: consecutive `clk` cycles a synchronised `ps2_clk` level must hold before the filtered clock accepts it.
- `TIMEOUT_CYCLES`, 200000: `clk` cycles (2 ms at 100 MHz) allowed between falling edges inside a frame before the frame is aborted.
- `clk` input 1: 100 MHz system clock; the only clock.
- `reset` input 1: asynchronous, active-low reset.
- `ps2_clk` input 1: raw PS/2 clock from the keyboard; asynchronous. The host never drives it.
- `ps2_data` input 1: raw PS/2 data from the keyboard; asynchronous.
- `key_code` output 8: scancode of the last event. Held until the next event.
- `key_release` output 1: the last event was preceded by F0.
- `key_extended` output 1: the last event was preceded by E0.
- `key_valid` output 1: one-cycle strobe marking a new event on `key_code`/flags.
- `parity_err` output 1: one-cycle strobe when a received frame fails odd parity.
- `frame_err` output 1: one-cycle strobe on a bad stop bit or a timeout.

## Operation
- **Input conditioning.** Each raw line passes through a 2-flop synchroniser.
  - Filtered clock `fclk` resets to 1. It takes the synchronised `ps2_clk` value only after that value has differed from `fclk` for `FILTER_LEN` consecutive cycles. Any shorter pulse is ignored.
  - A falling edge (`fe`) is a one-cycle pulse on an `fclk` 1→0 transition. Data is sampled from the synchronised `ps2_data` in the `fe` cycle.
- **Frame FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: on `fe` with data=0 (start bit), go to DATA and clear the bit counter. On `fe` with data=1, stay in IDLE with no error.
  - DATA: on each `fe`, shift the data bit into a shift register LSB-first and increment a 3-bit counter. After the 8th bit, go to PARITY.
  - PARITY: on `fe`, latch the parity bit and go to STOP.
  - STOP: on `fe`, evaluate the frame and go to IDLE.
    - Stop=0: `frame_err` pulse; byte dropped.
    - Stop=1 with an even count of ones over the 8 data bits plus the parity bit: `parity_err` pulse; byte dropped.
    - Otherwise the byte is good and is passed to the decoder.
  - Timeout: a counter is cleared on every `fe` and on entry to IDLE, and increments in DATA, PARITY and STOP. When it reaches `TIMEOUT_CYCLES`, the FSM goes to IDLE and pulses `frame_err`.
- **Prefix decoder** (acts on good bytes only).
  - 0xE0 sets the pending extended flag. 0xF0 sets the pending release flag. Neither produces `key_valid`.
  - Any other byte loads `key_code`, `key_release` and `key_extended` from itself and the pending flags, pulses `key_valid`, and clears both pending flags.
  - A `parity_err` or `frame_err` clears both pending flags.
  - Repeated prefixes are idempotent, e.g. E0 E0 1C gives extended=1.

## Timing
- Reset: all outputs 0, FSM in IDLE, pending flags 0, `fclk`=1, counters 0. Reset asserted mid-frame aborts the frame silently, with no error strobe.
- Edge latency: 2 sync cycles plus `FILTER_LEN` cycles from a raw `ps2_clk` fall to `fe`.
- `key_valid`, `parity_err` and `frame_err` are registered. Each is high exactly one cycle: the cycle after the stop-bit `fe`, or after the timeout count is reached.
- At most one of `key_valid`, `parity_err` and `frame_err` is high in any cycle.
- `key_code` and the flags change only in the `key_valid` cycle. They are stable at all other times.
- If the timeout expires in the same cycle as an `fe`, the `fe` wins and the counter clears.
- There is no back-pressure. Consumers must take the event in the `key_valid` cycle.

## Configuration
- `PS2_PREFIX_DECODE_EN` defined: prefix decoder as described above.
- `PS2_PREFIX_DECODE_EN` undefined:
  - Every good byte, including E0 and F0, pulses `key_valid` with `key_code` equal to the raw byte.
  - `key_release` and `key_extended` are tied to 0.
  - Pending-flag logic is removed.

## Test plan
- Good frame: byte 0x1C, parity 0, stop 1, bit period 50 µs → exactly one `key_valid`, `key_code`=0x1C, release=0, extended=0, no error strobes.
- Break sequence: frames E0, F0, 75 → a single `key_valid` after the third frame, `key_code`=0x75, release=1, extended=1. A following frame 1C gives release=0, extended=0.
- Bad parity: 0x1C sent with parity 1 → one `parity_err` pulse and no `key_valid`. Pending flags set by a preceding F0 are cleared.
- Stall: start bit plus 4 data bits, then the line held high for more than `TIMEOUT_CYCLES` → one `frame_err`. A following good 0x29 frame decodes correctly.
- Glitch rejection: 3-cycle low pulses on `ps2_clk` in IDLE and mid-frame → no bit shifted, and the frame still decodes to the sent byte.
- Reset mid-frame: `reset` asserted low after 5 bits, then released, then a full 0x5A frame → all outputs 0 during reset, no error strobe, then `key_code`=0x5A with `key_valid`.

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: filtered clock, 11-bit frame deserialiser and key event output.
// Define PS2_PREFIX_DECODE_EN to fold E0/F0 prefixes into key_extended/key_release.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_release,
  output logic       key_extended,
  output logic       key_valid,
  output logic       parity_err,
  output logic       frame_err
);

  // state  | meaning
  // IDLE   | waiting for a start bit
  // DATA   | shifting in 8 data bits, LSB first
  // PARITY | expecting the parity bit
  // STOP   | expecting the stop bit; frame judged on its edge

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} stateT;

  logic [1:0]    clkSync, dataSync;
  logic          dataS;
  logic          fclk, fe;
  logic [FW-1:0] filtCnt;
  stateT         stateQ, stateD;
  logic [2:0]    bitCnt;
  logic [7:0]    shiftQ;
  logic          parityQ;
  logic [TW-1:0] toCnt;
  logic          timeout;
  logic          goodD, parErrD, frmErrD;

  assign dataS = dataSync[1];

  // Lines idle high, so the synchronisers reset high to avoid a false edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clkSync  <= 2'b11;
      dataSync <= 2'b11;
    end else begin
      clkSync  <= {clkSync[0], ps2_clk};
      dataSync <= {dataSync[0], ps2_data};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fclk    <= 1'b1;
      filtCnt <= '0;
      fe      <= 1'b0;
    end else begin
      fe <= 1'b0;
      if (clkSync[1] != fclk) begin
        if (filtCnt == FILT_LAST) begin
          fclk    <= clkSync[1];
          filtCnt <= '0;
          fe      <= fclk;
        end else begin
          filtCnt <= filtCnt + FW'(1);
        end
      end else begin
        filtCnt <= '0;
      end
    end
  end

  // An edge arriving in the expiry cycle takes priority over the timeout.
  assign timeout = (stateQ != IDLE) && (toCnt == TO_LIMIT) && !fe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stateQ <= IDLE;
    else        stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (fe && !dataS)        stateD = DATA;
      DATA:    if (fe && bitCnt == 3'd7) stateD = PARITY;
      PARITY:  if (fe)                  stateD = STOP;
      STOP:    if (fe)                  stateD = IDLE;
      default:                          stateD = IDLE;
    endcase
    if (timeout) stateD = IDLE;
  end

  always_comb begin
    goodD   = 1'b0;
    parErrD = 1'b0;
    frmErrD = timeout;
    if (stateQ == STOP && fe) begin
      if (!dataS)                  frmErrD = 1'b1;
      else if (^{shiftQ, parityQ}) goodD   = 1'b1;
      else                         parErrD = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitCnt  <= '0;
      shiftQ  <= '0;
      parityQ <= 1'b0;
      toCnt   <= '0;
    end else begin
      if (fe) begin
        case (stateQ)
          IDLE:    if (!dataS) bitCnt <= '0;
          DATA: begin
            shiftQ <= {dataS, shiftQ[7:1]};
            bitCnt <= bitCnt + 3'd1;
          end
          PARITY:  parityQ <= dataS;
          default: ;
        endcase
      end
      if (stateQ == IDLE || fe)  toCnt <= '0;
      else if (toCnt != TO_LIMIT) toCnt <= toCnt + TW'(1);
    end
  end

`ifdef PS2_PREFIX_DECODE_EN
  logic pendExt, pendRel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_code     <= '0;
      key_release  <= 1'b0;
      key_extended <= 1'b0;
      key_valid    <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      pendExt      <= 1'b0;
      pendRel      <= 1'b0;
    end else begin
      key_valid  <= 1'b0;
      parity_err <= parErrD;
      frame_err  <= frmErrD;
      if (parErrD || frmErrD) begin
        pendExt <= 1'b0;
        pendRel <= 1'b0;
      end else if (goodD) begin
        if (shiftQ == 8'hE0) begin
          pendExt <= 1'b1;
        end else if (shiftQ == 8'hF0) begin
          pendRel <= 1'b1;
        end else begin
          key_code     <= shiftQ;
          key_release  <= pendRel;
          key_extended <= pendExt;
          key_valid    <= 1'b1;
          pendExt      <= 1'b0;
          pendRel      <= 1'b0;
        end
      end
    end
  end
`else
  assign key_release  = 1'b0;
  assign key_extended = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_code   <= '0;
      key_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      key_valid  <= goodD;
      parity_err <= parErrD;
      frame_err  <= frmErrD;
      if (goodD) key_code <= shiftQ;
    end
  end
`endif

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: directed frames plus randomised frames
// compared against a frame-level reference model of the key event stream.
module tb_ps2_keyboard_rx;

  localparam int FILT = 8;
  localparam int TMO  = 400;
  localparam int HP   = 40;

  logic       clk     = 1'b0;
  logic       rstN    = 1'b1;
  logic       ps2Clk  = 1'b1;
  logic       ps2Data = 1'b1;
  logic [7:0] keyCode;
  logic       keyRelease, keyExtended, keyValid, parityErr, frameErr;

  int nChecks = 0;
  int nFails  = 0;
  int nValid = 0, nPar = 0, nFrm = 0, multiStrobe = 0;

  logic [7:0] expCode = 8'h00;
  logic       expRel = 1'b0, expExt = 1'b0;
  logic       pendRel = 1'b0, pendExt = 1'b0;

  always #5 clk = ~clk;

  ps2_keyboard_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(rstN), .ps2_clk(ps2Clk), .ps2_data(ps2Data),
    .key_code(keyCode), .key_release(keyRelease), .key_extended(keyExtended),
    .key_valid(keyValid), .parity_err(parityErr), .frame_err(frameErr)
  );

  always @(negedge clk) begin
    if (keyValid)  nValid++;
    if (parityErr) nPar++;
    if (frameErr)  nFrm++;
    if (32'(keyValid) + 32'(parityErr) + 32'(frameErr) > 1) multiStrobe++;
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic badPar, input logic stopBit,
                           input int nBits, input logic glitch);
    logic [10:0] fr;
    fr = {stopBit, (~^b) ^ badPar, b, 1'b0};
    if (glitch) begin
      ps2Clk = 1'b0; repeat (3) @(negedge clk);
      ps2Clk = 1'b1; repeat (HP) @(negedge clk);
    end
    for (int i = 0; i < nBits; i++) begin
      ps2Data = fr[i];
      repeat (HP/2) @(negedge clk);
      ps2Clk = 1'b0;
      if (glitch) begin
        repeat (HP/2) @(negedge clk);
        ps2Clk = 1'b1; repeat (3) @(negedge clk);
        ps2Clk = 1'b0; repeat (HP/2 - 3) @(negedge clk);
      end else begin
        repeat (HP) @(negedge clk);
      end
      ps2Clk = 1'b1;
      if (glitch) begin
        repeat (HP/4) @(negedge clk);
        ps2Clk = 1'b0; repeat (3) @(negedge clk);
        ps2Clk = 1'b1; repeat (HP/2 - HP/4 - 3) @(negedge clk);
      end else begin
        repeat (HP/2) @(negedge clk);
      end
    end
    ps2Data = 1'b1;
  endtask

  // kind: 0 good frame, 1 wrong parity, 2 stop bit low
  task automatic doFrame(input logic [7:0] b, input int kind, input logic glitch, input string tag);
    int v0, p0, f0, eV, eP, eF;
    v0 = nValid; p0 = nPar; f0 = nFrm;
    sendFrame(b, kind == 1, kind != 2, 11, glitch);
    repeat (20) @(negedge clk);
    eV = 0; eP = 0; eF = 0;
    if (kind == 1) begin
      eP = 1; pendRel = 1'b0; pendExt = 1'b0;
    end else if (kind == 2) begin
      eF = 1; pendRel = 1'b0; pendExt = 1'b0;
    end else begin
`ifdef PS2_PREFIX_DECODE_EN
      if (b == 8'hE0)      pendExt = 1'b1;
      else if (b == 8'hF0) pendRel = 1'b1;
      else begin
        eV = 1; expCode = b; expRel = pendRel; expExt = pendExt;
        pendRel = 1'b0; pendExt = 1'b0;
      end
`else
      eV = 1; expCode = b; expRel = 1'b0; expExt = 1'b0;
`endif
    end
    checkVal({tag, "_valid"}, nValid - v0, eV);
    checkVal({tag, "_parerr"}, nPar - p0, eP);
    checkVal({tag, "_frmerr"}, nFrm - f0, eF);
    checkVal({tag, "_code"}, keyCode, expCode);
    checkVal({tag, "_rel"}, keyRelease, expRel);
    checkVal({tag, "_ext"}, keyExtended, expExt);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, "_code"}, keyCode, 0);
    checkVal({tag, "_rel"}, keyRelease, 0);
    checkVal({tag, "_ext"}, keyExtended, 0);
    checkVal({tag, "_valid"}, keyValid, 0);
    checkVal({tag, "_parerr"}, parityErr, 0);
    checkVal({tag, "_frmerr"}, frameErr, 0);
  endtask

  initial begin
    int v0, p0, f0;
    logic [7:0] b;
    int kind;
    #2 rstN = 1'b0;
    repeat (5) @(negedge clk);
    checkResetOutputs("reset");
    rstN = 1'b1;
    repeat (10) @(negedge clk);

    doFrame(8'h1C, 0, 1'b0, "good1c");
    doFrame(8'hE0, 0, 1'b0, "brk_e0");
    doFrame(8'hF0, 0, 1'b0, "brk_f0");
    doFrame(8'h75, 0, 1'b0, "brk_75");
    doFrame(8'h1C, 0, 1'b0, "after_brk");
    doFrame(8'hE0, 0, 1'b0, "rep_e0a");
    doFrame(8'hE0, 0, 1'b0, "rep_e0b");
    doFrame(8'h1C, 0, 1'b0, "rep_1c");
    doFrame(8'hF0, 0, 1'b0, "pre_bad");
    doFrame(8'h1C, 1, 1'b0, "badpar");
    doFrame(8'h1C, 0, 1'b0, "post_bad");
    doFrame(8'h42, 2, 1'b0, "badstop");

    v0 = nValid; p0 = nPar; f0 = nFrm;
    sendFrame(8'h29, 1'b0, 1'b1, 5, 1'b0);
    repeat (TMO + 200) @(negedge clk);
    pendRel = 1'b0; pendExt = 1'b0;
    checkVal("stall_frmerr", nFrm - f0, 1);
    checkVal("stall_valid", nValid - v0, 0);
    checkVal("stall_parerr", nPar - p0, 0);
    doFrame(8'h29, 0, 1'b0, "post_stall");

    doFrame(8'h3A, 0, 1'b1, "glitch");

    sendFrame(8'hA5, 1'b0, 1'b1, 5, 1'b0);
    repeat (10) @(negedge clk);
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("midrst");
    rstN = 1'b1;
    expCode = 8'h00; expRel = 1'b0; expExt = 1'b0; pendRel = 1'b0; pendExt = 1'b0;
    v0 = nValid; p0 = nPar; f0 = nFrm;
    repeat (TMO + 100) @(negedge clk);
    checkVal("midrst_frmerr", nFrm - f0, 0);
    checkVal("midrst_parerr", nPar - p0, 0);
    checkVal("midrst_valid", nValid - v0, 0);
    doFrame(8'h5A, 0, 1'b0, "post_rst");

    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 5))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      kind = $urandom_range(0, 9);
      kind = (kind < 7) ? 0 : (kind == 7) ? 1 : 2;
      doFrame(b, kind, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    checkVal("one_strobe", multiStrobe, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
